// File: rtl/tensor_core_pkg.sv
// Shared decode constants, sequencer state encoding and address-width helper
// for the tensor core sequencer and its burst counter.
package tensor_core_pkg;

  localparam logic [1:0] OPC_GENERIC = 2'b00;
  localparam logic [1:0] OPC_OPERATE = 2'b10;
  localparam logic [1:0] OPC_BURST   = 2'b11;

  localparam logic [1:0] GEN_SOFT_RST = 2'b11;

  localparam logic [1:0] SEL_M0   = 2'b00;
  localparam logic [1:0] SEL_M1   = 2'b01;
  localparam logic [1:0] SEL_BOTH = 2'b10;
  localparam logic [1:0] SEL_BAD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_BURST_WRITE = 3'd1,
    ST_BURST_READ  = 3'd2,
    ST_COMPUTE     = 3'd3,
    ST_COMMIT      = 3'd4
  } seq_state_t;

  function automatic int calc_addr_w(input int num_matrices, input int dim);
    int w;
    w = $clog2(num_matrices * dim * dim);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tensor_core_sequencer_if.sv
// Instruction, register-file and tensor-core signals of the sequencer;
// master is the sequencer side, slave the CPU/register-file/core side.
interface tensor_core_sequencer_if
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int MATRIX_DIM   = 3,
  parameter int NUM_MATRICES = 2,
  parameter int INSTR_WIDTH  = 16
);
  localparam int LANES  = INSTR_WIDTH / DATA_WIDTH;
  localparam int ADDR_W = calc_addr_w(NUM_MATRICES, MATRIX_DIM);

  logic [INSTR_WIDTH-1:0]       current_instruction_in;
  logic                         busy_out;
  logic                         error_out;
  logic [LANES-1:0]             elem_write_enable_out;
  logic [LANES*ADDR_W-1:0]      elem_write_address_out;
  logic [LANES*DATA_WIDTH-1:0]  elem_write_data_out;
  logic [ADDR_W-1:0]            elem_read_address_out;
  logic [DATA_WIDTH-1:0]        elem_read_data_in;
  logic signed [DATA_WIDTH-1:0] cpu_output;
  logic                         cpu_output_valid_out;
  logic                         core_start_out;
  logic [2:0]                   core_op_select_out;
  logic                         bulk_write_enable_out;

  modport master (
    input  current_instruction_in, elem_read_data_in,
    output busy_out, error_out, elem_write_enable_out, elem_write_address_out,
           elem_write_data_out, elem_read_address_out, cpu_output,
           cpu_output_valid_out, core_start_out, core_op_select_out,
           bulk_write_enable_out
  );

  modport slave (
    output current_instruction_in, elem_read_data_in,
    input  busy_out, error_out, elem_write_enable_out, elem_write_address_out,
           elem_write_data_out, elem_read_address_out, cpu_output,
           cpu_output_valid_out, core_start_out, core_op_select_out,
           bulk_write_enable_out
  );

endinterface

// File: rtl/tensor_core_burst_counter.sv
// Range walker shared by burst read and write: base/count/index registers,
// per-lane addresses and in-range enables, last-step flag; addresses are registered.
module tensor_core_burst_counter #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6,
  parameter int LANES  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic [ADDR_W-1:0]        i_base,
  input  logic [CNT_W-1:0]         i_count,
  input  logic                     i_advance,
  input  logic                     i_wide,
  output logic [LANES*ADDR_W-1:0]  o_lane_addr,
  output logic [LANES-1:0]         o_lane_en,
  output logic [ADDR_W-1:0]        o_rd_addr,
  output logic                     o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  w_step;
  logic [CNT_W-1:0]  w_next;

  assign w_step    = i_wide ? CNT_W'(LANES) : CNT_W'(1);
  assign w_next    = r_idx + w_step;
  assign o_last    = (w_next >= r_count);
  assign o_rd_addr = r_base + r_idx[ADDR_W-1:0];

  // Lanes beyond the range end still get an address but are never enabled.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CNT_W-1:0] w_pos;
    assign w_pos = r_idx + CNT_W'(k);
    assign o_lane_addr[k*ADDR_W +: ADDR_W] = r_base + w_pos[ADDR_W-1:0];
    assign o_lane_en[k] = (w_pos < r_count);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base  <= '0;
      r_count <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_base  <= i_base;
      r_count <= i_count;
      r_idx   <= '0;
    end else if (i_advance) begin
      r_idx   <= w_next;
    end
  end

endmodule

// File: rtl/tensor_core_sequencer.sv
// Decodes burst/operate/soft-reset instructions and sequences register-file bursts
// and tensor-core compute/commit; one beat or element per cycle, no stall input.
module tensor_core_sequencer
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MATRIX_DIM      = 3,
  parameter int NUM_MATRICES    = 2,
  parameter int INSTR_WIDTH     = 16,
  parameter int COMPUTE_LATENCY = 4
) (
  input  logic                    clock_in,
  input  logic                    reset_n_in,
  tensor_core_sequencer_if.master bus
);

  localparam int LANES  = INSTR_WIDTH / DATA_WIDTH;
  localparam int ADDR_W = calc_addr_w(NUM_MATRICES, MATRIX_DIM);
  localparam int MAT_SZ = MATRIX_DIM * MATRIX_DIM;
  localparam int CNT_W  = $clog2(NUM_MATRICES * MAT_SZ + LANES) + 1;
  localparam int LAT_W  = (COMPUTE_LATENCY > 1) ? $clog2(COMPUTE_LATENCY) : 1;

  seq_state_t        r_state;
  logic [2:0]        r_op_sel;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_error;

  logic [INSTR_WIDTH-1:0]      w_instr;
  logic [1:0]                  w_opc;
  logic [1:0]                  w_msel;
  logic                        w_rw;
  logic                        w_soft_rst;
  logic                        w_illegal;
  logic                        w_load;
  logic [ADDR_W-1:0]           w_base;
  logic [CNT_W-1:0]            w_count;
  logic [LANES*ADDR_W-1:0]     w_lane_addr;
  logic [LANES-1:0]            w_lane_en;
  logic [ADDR_W-1:0]           w_rd_addr;
  logic                        w_last;
  logic [LANES*DATA_WIDTH-1:0] w_lane_dat;

  assign w_instr    = bus.current_instruction_in;
  assign w_opc      = w_instr[1:0];
  assign w_rw       = w_instr[2];
  assign w_msel     = w_instr[4:3];
  assign w_soft_rst = (w_opc == OPC_GENERIC) && (w_instr[3:2] == GEN_SOFT_RST);
  assign w_illegal  = (w_opc == OPC_BURST) || (w_opc == OPC_OPERATE);
  assign w_load     = (r_state == ST_IDLE) && (w_opc == OPC_BURST) && (w_msel != SEL_BAD);

  always_comb begin
    w_base  = '0;
    w_count = CNT_W'(MAT_SZ);
    case (w_msel)
      SEL_M1:   w_base  = ADDR_W'(MAT_SZ);
      SEL_BOTH: w_count = CNT_W'(2 * MAT_SZ);
      default:  ;
    endcase
  end

  tensor_core_burst_counter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .LANES  (LANES)
  ) u_burst_counter (
    .i_clk       (clock_in),
    .i_rst_n     (reset_n_in),
    .i_load      (w_load),
    .i_base      (w_base),
    .i_count     (w_count),
    .i_advance   ((r_state == ST_BURST_WRITE) || (r_state == ST_BURST_READ)),
    .i_wide      (r_state == ST_BURST_WRITE),
    .o_lane_addr (w_lane_addr),
    .o_lane_en   (w_lane_en),
    .o_rd_addr   (w_rd_addr),
    .o_last      (w_last)
  );

  // Lane 0 takes the most significant element of the beat.
  for (genvar k = 0; k < LANES; k++) begin : g_dat
    assign w_lane_dat[k*DATA_WIDTH +: DATA_WIDTH] =
      w_instr[INSTR_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH];
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state   <= ST_IDLE;
      r_op_sel  <= '0;
      r_lat_cnt <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_lat_cnt <= '0;
          if (w_opc == OPC_BURST) begin
            if (w_msel == SEL_BAD) r_error <= 1'b1;
            else r_state <= w_rw ? ST_BURST_WRITE : ST_BURST_READ;
          end else if (w_opc == OPC_OPERATE) begin
            r_op_sel <= w_instr[4:2];
            r_state  <= ST_COMPUTE;
          end
        end
        // Every beat is data here, so no opcode can abort a write burst.
        ST_BURST_WRITE: if (w_last) r_state <= ST_IDLE;
        default: begin
          if (w_illegal) r_error <= 1'b1;
          if (w_soft_rst) begin
            r_state <= ST_IDLE;
          end else if (r_state == ST_BURST_READ) begin
            if (w_last) r_state <= ST_IDLE;
          end else if (r_state == ST_COMPUTE) begin
            if (r_lat_cnt == LAT_W'(COMPUTE_LATENCY - 1)) r_state <= ST_COMMIT;
            else r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.busy_out               = (r_state != ST_IDLE);
    bus.error_out              = r_error;
    bus.elem_write_enable_out  = '0;
    bus.elem_write_address_out = '0;
    bus.elem_write_data_out    = '0;
    bus.elem_read_address_out  = '0;
    bus.cpu_output             = '0;
    bus.cpu_output_valid_out   = 1'b0;
    bus.core_start_out         = 1'b0;
    bus.core_op_select_out     = '0;
    bus.bulk_write_enable_out  = 1'b0;
    case (r_state)
      ST_BURST_WRITE: begin
        bus.elem_write_enable_out  = w_lane_en;
        bus.elem_write_address_out = w_lane_addr;
        bus.elem_write_data_out    = w_lane_dat;
      end
      ST_BURST_READ: begin
        bus.elem_read_address_out = w_rd_addr;
        bus.cpu_output            = bus.elem_read_data_in;
        bus.cpu_output_valid_out  = 1'b1;
      end
      ST_COMPUTE: begin
        bus.core_start_out     = (r_lat_cnt == '0);
        bus.core_op_select_out = r_op_sel;
      end
      ST_COMMIT: begin
        bus.core_op_select_out    = r_op_sel;
        bus.bulk_write_enable_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/tensor_core_sequencer.md
Name: tensor_core_sequencer

Overview:
Parametrised successor to the fixed 3x3 burst/operate control in the CPU. It decodes burst-read, burst-write, operate and soft-reset instructions and runs the burst and compute sequences for a configurable matrix size, matrix count and compute latency. It sits between the instruction stream and the tensor core register file and tensor core. Load-immediate and move decoding stay in the CPU; this block only blocks them while it is busy.

Parameters:
DATA_WIDTH, 8, element width in bits (signed)
MATRIX_DIM, 3, rows = cols per matrix (N)
NUM_MATRICES, 2, matrices in register file
INSTR_WIDTH, 16, instruction width; LANES = INSTR_WIDTH/DATA_WIDTH write elements per beat
COMPUTE_LATENCY, 4, tensor core cycles from start to result valid (>=1)

Ports:
clock_in  in  1  system clock
reset_n_in  in  1  asynchronous active-low reset
current_instruction_in  in  INSTR_WIDTH  instruction/data beat
busy_out  out  1  sequencer not IDLE; CPU gates non-bulk writes with it
error_out  out  1  sticky illegal-command flag
elem_write_enable_out  out  LANES  per-lane element write enable
elem_write_address_out  out  LANES*ADDR_W  flat element address per lane, ADDR_W=$clog2(NUM_MATRICES*N*N)
elem_write_data_out  out  LANES*DATA_WIDTH  lane 0 = instr MSBs
elem_read_address_out  out  ADDR_W  flat read address
elem_read_data_in  in  DATA_WIDTH  combinational read data from register file
cpu_output  out  DATA_WIDTH  signed burst-read data
cpu_output_valid_out  out  1  cpu_output holds a burst element
core_start_out  out  1  one-cycle tensor core start
core_op_select_out  out  3  operation select, held through compute
bulk_write_enable_out  out  1  one-cycle commit of tensor core output

Behaviour:
- Instruction fields: opcode[1:0] (00 generic, 10 operate, 11 burst). Generic opselect[3:2]==11 is soft reset. Burst fields: [2] r/w (1 = write), [4:3] matrix select (00 m0, 01 m1, 10 both, 11 illegal). Operate field: [4:2] op select.
- Flat address = matrix*N*N + row*N + col, row-major. Range base/count: m0 = 0/N*N, m1 = N*N/N*N, both = 0/2*N*N.
- States: IDLE, BURST_WRITE, BURST_READ, COMPUTE, COMMIT.
- Async reset: state IDLE, counters 0, error_out 0, all outputs 0.
- IDLE: command sampled at posedge. Burst write goes to BURST_WRITE, burst read to BURST_READ, operate to COMPUTE. Matrix select 11 sets error_out and stays IDLE.
- BURST_WRITE: every instruction is data. Soft-reset opcodes are not decoded here; only reset_n_in aborts.
  - Beats = ceil(count/LANES). Lane k writes base + beat*LANES + k.
  - Enables are combinational in-state. A lane past count is disabled (3x3, m0: 5 beats, last beat lane 1 off).
  - IDLE after the last beat's edge.
- BURST_READ: one element per cycle for count cycles. Read address registered, starts at base. cpu_output = elem_read_data_in, valid = 1. IDLE after the last element.
- COMPUTE:
  - core_start_out high only in the first COMPUTE cycle.
  - core_op_select_out is latched at accept.
  - Counter runs COMPUTE_LATENCY cycles, then COMMIT.
- COMMIT: bulk_write_enable_out = 1 for exactly one cycle, then IDLE.
- In BURST_READ, COMPUTE or COMMIT:
  - Soft reset returns to IDLE at the next edge with outputs deasserted; it does not clear error_out.
  - Burst or operate opcodes set error_out and are ignored.
  - Generic NOP, move and read are ignored silently.
- Partial writes done before an abort remain in the register file. A compute aborted before COMMIT never commits.
- busy_out = (state != IDLE), combinational. error_out clears only on reset_n_in.

Decomposition:
- Package tensor_core_pkg: opcode, generic opselect and burst select constants; sequencer state enum; ADDR_W helper function.
- One sub-module, tensor_core_burst_counter, holds base/count/beat index and emits lane addresses, lane enables and a last flag. It is shared by the read and write paths.

Test Plan:
1. Burst write m0, then 5 beats 0x0102, 0x0304, 0x0506, 0x0708, 0x09xx -> addresses 0..8 get data 1..9; lane 1 disabled on beat 5; busy 5 cycles.
2. Burst read both after loading values 0..17 -> 18 consecutive valid cycles, cpu_output 0..17, addresses 0..17, then valid = 0.
3. Operate op 3 with COMPUTE_LATENCY=4 -> core_start_out on cycle 1 only; op select = 3 held; bulk_write_enable_out on cycle 5 only; busy 5 cycles.
4. Soft reset during burst read after element 4 -> valid low next cycle, state IDLE, a new burst accepted the following cycle.
5. Burst command during COMPUTE, then matrix select 11 in IDLE -> error_out set and stays set; compute completes normally; no burst started.
6. reset_n_in low mid burst write (beat 2) -> outputs 0 immediately (async); after release a new burst write starts at base address.
